// File: rtl/raising_edge_det.sv
// rtl/raising_edge_det.sv - registered 0->1 transition detector
// Two-stage sample history feeds a flopped pulse so the output never sees Test_Singal combinationally.
module raising_edge_det #(
  parameter logic INIT_HIST = 1'b0
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic Test_Singal,
  output logic Raisung
);

  logic s_cur;
  logic s_prev;
  logic r_raisung;

  // ARESETN is active-high despite its name; it is sampled only on ACLK.
  always_ff @(posedge ACLK) begin
    if (ARESETN) begin
      s_cur     <= INIT_HIST;
      s_prev    <= INIT_HIST;
      r_raisung <= 1'b0;
    end else begin
      s_cur     <= Test_Singal;
      s_prev    <= s_cur;
      r_raisung <= s_cur & ~s_prev;
    end
  end

  assign Raisung = r_raisung;

endmodule

// File: tb/tb_raising_edge_det.sv
// tb/tb_raising_edge_det.sv - scoreboard bench for raising_edge_det
// Drives a hand-derived stimulus table into INIT_HIST=0 and INIT_HIST=1 instances.
module tb_raising_edge_det;

  logic ACLK;
  logic ARESETN;
  logic Test_Singal;
  logic w_rise0;
  logic w_rise1;

  int n_checks;
  int n_errors;

  raising_edge_det #(.INIT_HIST(1'b0)) u_dut0 (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .Test_Singal (Test_Singal),
    .Raisung     (w_rise0)
  );

  raising_edge_det #(.INIT_HIST(1'b1)) u_dut1 (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .Test_Singal (Test_Singal),
    .Raisung     (w_rise1)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // rst, x, glitch-between-edges, expected Raisung after the edge for INIT_HIST=0 / 1
  typedef struct packed {
    logic rst;
    logic x;
    logic g;
    logic e0;
    logic e1;
  } step_t;

  localparam int N_STEPS = 38;
  step_t tbl [N_STEPS] = '{
    5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000,
    5'b01000, 5'b01011, 5'b01000, 5'b01100, 5'b01000,
    5'b00000, 5'b00000,
    5'b00000, 5'b01000, 5'b00011, 5'b00000, 5'b01000, 5'b00111, 5'b00000,
    5'b01000, 5'b01011, 5'b11000, 5'b11000, 5'b01000, 5'b01010, 5'b01100,
    5'b00000, 5'b01000, 5'b00011, 5'b01000, 5'b01011, 5'b01000, 5'b01000,
    5'b11000, 5'b10000, 5'b11000, 5'b00000, 5'b00000
  };

  typedef struct {
    int   idx;
    logic e0;
    logic e1;
  } exp_t;

  exp_t sb_q[$];
  bit   drv_done;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Monitor: one scoreboard entry per driven edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge ACLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq($sformatf("step%0d_init0", e.idx), w_rise0, e.e0);
        check_eq($sformatf("step%0d_init1", e.idx), w_rise1, e.e1);
      end
    end
  end

  initial begin
    exp_t e;
    n_checks    = 0;
    n_errors    = 0;
    drv_done    = 1'b0;
    ARESETN     = 1'b1;
    Test_Singal = 1'b0;

    for (int i = 0; i < N_STEPS; i++) begin
      @(negedge ACLK);
      ARESETN     = tbl[i].rst;
      Test_Singal = tbl[i].x;
      e.idx = i + 1;
      e.e0  = tbl[i].e0;
      e.e1  = tbl[i].e1;
      sb_q.push_back(e);
      if (tbl[i].g) begin
        #1;
        ARESETN     = ~tbl[i].rst;
        Test_Singal = ~tbl[i].x;
        #2;
        ARESETN     = tbl[i].rst;
        Test_Singal = tbl[i].x;
      end
    end

    for (int w = 0; w < 5 && sb_q.size() > 0; w++) begin
      @(posedge ACLK);
      #2;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    drv_done = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
